fixed_priority_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 23 ++
 rtl/fixed_priority_arbiter_if.sv | 29 ++
 rtl/fixed_priority_pick.sv | 14 +
 rtl/fixed_priority_arbiter.sv | 58 +++++
 tb/tb_fixed_priority_arbiter.sv | 118 +++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: default width and one-hot to binary encoder.
// Latency: none (package of constants and pure functions).
// Backpressure: not applicable.
package arb_pkg;

  localparam int ARB_N_DEFAULT = 3;
  localparam int ARB_N_MAX     = 32;
  localparam int ARB_IDW_MAX   = 5;

  // Encodes a one-hot vector, zero-extended to ARB_N_MAX bits, into its bit index.
  // An all-zero vector encodes to 0. Callers truncate the result to their own index width.
  function automatic logic [ARB_IDW_MAX-1:0] onehot2bin(input logic [ARB_N_MAX-1:0] vec);
    logic [ARB_IDW_MAX-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_N_MAX; i++) begin
      if (vec[i]) begin
        idx = idx | ARB_IDW_MAX'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fixed_priority_arbiter_if.sv
// Request/grant bundle between requestors and the fixed-priority arbiter.
// Latency: none (wires only).
// Backpressure: none; requests are re-evaluated every cycle.
interface fixed_priority_arbiter_if #(
  parameter int N = arb_pkg::ARB_N_DEFAULT
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic           grant_vld;
  logic [IDW-1:0] grant_idx;

  // Requestor side: drives requests, observes the grant.
  modport master (
    output req,
    input  grant,
    input  grant_vld,
    input  grant_idx
  );

  // Arbiter side: consumes requests, produces the grant.
  modport slave (
    input  req,
    output grant,
    output grant_vld,
    output grant_idx
  );
endinterface

// File: rtl/fixed_priority_pick.sv
// Isolates the lowest set bit of the request vector (bit 0 has highest priority).
// Latency: purely combinational.
// Backpressure: none; winner follows req directly, zero when req is zero.
module fixed_priority_pick #(
  parameter int N = arb_pkg::ARB_N_DEFAULT
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] winner
);

  // Two's-complement trick: req & -req keeps only the lowest set bit.
  assign winner = req & (~req + N'(1));

endmodule

// File: rtl/fixed_priority_arbiter.sv
// Fixed-priority arbiter: lowest-indexed active request wins, registered one-hot grant + index.
// Latency: 1 cycle from req sample to grant/grant_vld/grant_idx.
// Backpressure: none; no hold or lock, grant tracks req every cycle and higher priority preempts.
module fixed_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N = ARB_N_DEFAULT
) (
  input logic                    clk,
  input logic                    rst,
  fixed_priority_arbiter_if.slave bus
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   winner;
  logic [IDW-1:0] winner_idx;

  fixed_priority_pick #(.N(N)) u_pick (
    .req    (bus.req),
    .winner (winner)
  );

  // Encode the one-hot winner; zero winner encodes to index 0.
  always_comb begin
    winner_idx = IDW'(onehot2bin(ARB_N_MAX'(winner)));
  end

  // Output register bank; reset clears outputs immediately, independent of clk.
  // grant_vld comes straight from |req so an X in a higher-index bit cannot
  // mask a known 1 in a lower-index bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.grant     <= '0;
      bus.grant_vld <= 1'b0;
      bus.grant_idx <= '0;
    end else begin
      bus.grant     <= winner;
      bus.grant_vld <= |bus.req;
      bus.grant_idx <= winner_idx;
    end
  end

`ifndef SYNTHESIS
  // Grant is never more than one bit.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.grant));

  // Valid flag agrees with the grant vector.
  a_vld_matches: assert property (@(posedge clk) disable iff (rst)
    bus.grant_vld == (|bus.grant));

  // Index points at the granted bit, and is zero when nothing is granted.
  a_idx_matches: assert property (@(posedge clk) disable iff (rst)
    bus.grant_vld ? bus.grant[bus.grant_idx] : (bus.grant_idx == '0));
`endif

endmodule

// File: tb/tb_fixed_priority_arbiter.sv
module tb_fixed_priority_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fixed_priority_arbiter_if #(.N(3)) bus ();

  fixed_priority_arbiter #(.N(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [2:0] eg, input logic ev, input logic [1:0] ei);
    check({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    check({tag, ".vld"},   32'(bus.grant_vld), 32'(ev));
    check({tag, ".idx"},   32'(bus.grant_idx), 32'(ei));
  endtask

  // Apply req at a falling edge, let one rising edge pass, check at next falling edge.
  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] eg,
                      input logic ev, input logic [1:0] ei);
    bus.req = r;
    @(negedge clk);
    check_out(tag, eg, ev, ei);
  endtask

  function automatic logic [2:0] lowest_bit(input logic [2:0] r);
    if (r[0]) return 3'b001;
    if (r[1]) return 3'b010;
    if (r[2]) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [1:0] bit_index(input logic [2:0] g);
    if (g[1]) return 2'd1;
    if (g[2]) return 2'd2;
    return 2'd0;
  endfunction

  initial begin
    logic [2:0] r;
    logic [2:0] eg;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.req = 3'b000;
    repeat (2) @(negedge clk);
    check_out("reset", 3'b000, 1'b0, 2'd0);
    rst = 1'b0;

    // First edge after reset samples req normally.
    step("first_after_rst", 3'b100, 3'b100, 1'b1, 2'd2);

    // Single requests.
    step("single_100", 3'b100, 3'b100, 1'b1, 2'd2);
    step("single_010", 3'b010, 3'b010, 1'b1, 2'd1);
    step("single_001", 3'b001, 3'b001, 1'b1, 2'd0);

    // Contention.
    step("cont_101", 3'b101, 3'b001, 1'b1, 2'd0);
    step("cont_011", 3'b011, 3'b001, 1'b1, 2'd0);
    step("cont_110", 3'b110, 3'b010, 1'b1, 2'd1);
    step("cont_111", 3'b111, 3'b001, 1'b1, 2'd0);

    // Preemption and return.
    step("pre_hold0", 3'b100, 3'b100, 1'b1, 2'd2);
    step("pre_hold1", 3'b100, 3'b100, 1'b1, 2'd2);
    step("pre_hold2", 3'b100, 3'b100, 1'b1, 2'd2);
    step("pre_take",  3'b101, 3'b001, 1'b1, 2'd0);
    step("pre_back",  3'b100, 3'b100, 1'b1, 2'd2);

    // Idle.
    step("idle", 3'b000, 3'b000, 1'b0, 2'd0);

    // Asynchronous reset in the middle of a grant.
    step("rst_pre", 3'b111, 3'b001, 1'b1, 2'd0);
    #2 rst = 1'b1;
    #1 check_out("rst_async", 3'b000, 1'b0, 2'd0);
    // req changes while rst is held: reset wins.
    bus.req = 3'b010;
    @(negedge clk);
    check_out("rst_wins", 3'b000, 1'b0, 2'd0);
    rst = 1'b0;
    step("rst_release", 3'b010, 3'b010, 1'b1, 2'd1);

    // Randomized traffic against a bench-side priority model.
    for (int i = 0; i < 1000; i++) begin
      r  = 3'($urandom_range(0, 7));
      eg = lowest_bit(r);
      step("rand", r, eg, (r != 3'b000), bit_index(eg));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
